// File: rtl/priority_in_service_if.sv
// Bundles the signals between the priority resolver / in-service stage and
// the rest of the interrupt controller.
//   master : drives requests, mask, mode, rotation and strobes; observes results
//   slave  : the resolver itself; consumes the controls and returns
//            interrupt, in_service_register and highest_level_in_service
interface priority_in_service_if;
    logic [7:0] interrupt_request_register;
    logic [7:0] interrupt_mask;
    logic       special_fully_nest_config;
    logic [2:0] priority_rotate;
    logic       latch_in_service;
    logic [7:0] end_of_interrupt;
    logic [7:0] interrupt;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;

    modport master (
        output interrupt_request_register,
        output interrupt_mask,
        output special_fully_nest_config,
        output priority_rotate,
        output latch_in_service,
        output end_of_interrupt,
        input  interrupt,
        input  in_service_register,
        input  highest_level_in_service
    );

    modport slave (
        input  interrupt_request_register,
        input  interrupt_mask,
        input  special_fully_nest_config,
        input  priority_rotate,
        input  latch_in_service,
        input  end_of_interrupt,
        output interrupt,
        output in_service_register,
        output highest_level_in_service
    );
endinterface

// File: rtl/priority_in_service.sv
// Priority resolver and In-Service Register of an 8259A-style interrupt
// controller. Picks the highest-priority unmasked request under rotating
// priority, gates it against the in-service level (fully nested or special
// fully nested), and maintains the ISR from latch / EOI strobes.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : requests, mask, SFNM, rotation, latch/EOI strobes in;
//                  registered one-hot interrupt, ISR, and one-hot highest
//                  in-service level out
module priority_in_service #(
    parameter int NUM_LEVELS = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    priority_in_service_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_LEVELS);

    // Rotate right by n, used to move the highest-priority level to bit 0.
    function automatic logic [NUM_LEVELS-1:0] rotate_right(
        input logic [NUM_LEVELS-1:0] v, input logic [IDX_W-1:0] n);
        logic [2*NUM_LEVELS-1:0] tmp;
        tmp = {v, v} >> n;
        return tmp[NUM_LEVELS-1:0];
    endfunction

    function automatic logic [NUM_LEVELS-1:0] rotate_left(
        input logic [NUM_LEVELS-1:0] v, input logic [IDX_W-1:0] n);
        logic [2*NUM_LEVELS-1:0] tmp;
        tmp = {v, v} << n;
        return tmp[2*NUM_LEVELS-1:NUM_LEVELS];
    endfunction

    // Isolate the lowest set bit (two's-complement trick).
    function automatic logic [NUM_LEVELS-1:0] lowest_one(
        input logic [NUM_LEVELS-1:0] v);
        return v & (~v + {{(NUM_LEVELS-1){1'b0}}, 1'b1});
    endfunction

    function automatic logic [IDX_W-1:0] one_hot_index(
        input logic [NUM_LEVELS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    logic [NUM_LEVELS-1:0] isr;
    logic [NUM_LEVELS-1:0] interrupt_q;
    logic [IDX_W-1:0]      rotate_amount;
    logic [NUM_LEVELS-1:0] masked_request;
    logic [NUM_LEVELS-1:0] candidate_rot;
    logic [NUM_LEVELS-1:0] isr_top_rot;
    logic [NUM_LEVELS-1:0] candidate;
    logic                  candidate_allowed;

    // priority_rotate names the lowest level, so the highest sits one above;
    // 3-bit wrap gives the mod-8 for free.
    assign rotate_amount  = bus.priority_rotate + 3'd1;
    assign masked_request = bus.interrupt_request_register & ~bus.interrupt_mask;

    // In the rotated domain a lower bit index means higher priority.
    assign candidate_rot = lowest_one(rotate_right(masked_request, rotate_amount));
    assign isr_top_rot   = lowest_one(rotate_right(isr, rotate_amount));

    always_comb begin
        candidate_allowed = 1'b0;
        if (candidate_rot != '0) begin
            if (isr == '0)
                candidate_allowed = 1'b1;
            else if (one_hot_index(candidate_rot) < one_hot_index(isr_top_rot))
                candidate_allowed = 1'b1;
            else if (bus.special_fully_nest_config &&
                     one_hot_index(candidate_rot) == one_hot_index(isr_top_rot))
                candidate_allowed = 1'b1;
        end
    end

    assign candidate = candidate_allowed ? rotate_left(candidate_rot, rotate_amount) : '0;

    // Registered interrupt and ISR. During a latch the request is still
    // visible in the IRR, so the output is forced low for that cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            interrupt_q <= '0;
            isr         <= '0;
        end else begin
            interrupt_q <= bus.latch_in_service ? '0 : candidate;
            isr         <= (isr & ~bus.end_of_interrupt) |
                           (bus.latch_in_service ? interrupt_q : '0);
        end
    end

    assign bus.interrupt                = interrupt_q;
    assign bus.in_service_register      = isr;
    assign bus.highest_level_in_service = rotate_left(isr_top_rot, rotate_amount);
endmodule
